link_order_queue: RTL and testbench

LINK_ORDER_QUEUE -- requirements
Module: link_order_queue

---
 rtl/link_order_queue.sv | 103 ++++++++++
 tb/tb_link_order_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_order_queue.sv
// First-word-fall-through order queue feeding a link manager.
// Holds issue of READ orders once MAX_RD results are still outstanding.
module link_order_queue #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TABLE_WIDTH = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned MAX_RD      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_busy,
    input  logic [1:0]               in_type,
    input  logic [TABLE_WIDTH-1:0]   in_table,
    input  logic [ADDR_WIDTH-1:0]    in_node,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     order_valid,
    input  logic                     order_busy,
    output logic [1:0]               order_type,
    output logic [TABLE_WIDTH-1:0]   order_table,
    output logic [ADDR_WIDTH-1:0]    order_node,
    output logic [DATA_WIDTH-1:0]    order_data,
    input  logic                     dout_valid,
    input  logic                     dout_busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               rd_outstanding,
    output logic                     rsp_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned EW = 2 + TABLE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [1:0]  TYPE_READ = 2'd3;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          head_read;
    logic          rd_full;
    logic          rd_inc;
    logic          rd_dec;

    // Head entry is shown directly from storage (fall-through).
    assign {order_type, order_table, order_node, order_data} = mem[rd_ptr];

    assign head_read   = (order_type == TYPE_READ);
    assign rd_full     = (rd_outstanding == 8'(MAX_RD));
    assign in_busy     = (level == LW'(DEPTH));
    assign order_valid = (level != '0) && !(head_read && rd_full);
    assign push        = in_valid && !in_busy;
    assign pop         = order_valid && !order_busy;
    assign rd_inc      = pop && head_read;
    assign rd_dec      = dout_valid && !dout_busy;

    // Storage is not reset; stale contents are hidden behind level==0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_type, in_table, in_node, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Outstanding READ tracking; a consume with nothing outstanding is flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_outstanding <= '0;
            rsp_err        <= 1'b0;
        end else begin
            if (rd_inc && !rd_dec) begin
                rd_outstanding <= rd_outstanding + 8'(1);
            end else if (rd_dec && !rd_inc) begin
                if (rd_outstanding == '0) begin
                    rsp_err <= 1'b1;
                end else begin
                    rd_outstanding <= rd_outstanding - 8'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_link_order_queue.sv
// Bench for link_order_queue: directed vectors, corner sequences and a
// randomized run against a queue-based reference model.
module tb_link_order_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_busy;
    logic [1:0]  in_type;
    logic [7:0]  in_table;
    logic [15:0] in_node;
    logic [15:0] in_data;
    logic        order_valid;
    logic        order_busy;
    logic [1:0]  order_type;
    logic [7:0]  order_table;
    logic [15:0] order_node;
    logic [15:0] order_data;
    logic        dout_valid;
    logic        dout_busy;
    logic [3:0]  level;
    logic [7:0]  rd_outstanding;
    logic        rsp_err;

    link_order_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_busy(in_busy), .in_type(in_type),
        .in_table(in_table), .in_node(in_node), .in_data(in_data),
        .order_valid(order_valid), .order_busy(order_busy),
        .order_type(order_type), .order_table(order_table),
        .order_node(order_node), .order_data(order_data),
        .dout_valid(dout_valid), .dout_busy(dout_busy),
        .level(level), .rd_outstanding(rd_outstanding), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  t;
        logic [7:0]  tb;
        logic [15:0] nd;
        logic [15:0] dt;
    } ord_t;

    typedef struct {
        logic        iv;
        logic [1:0]  ty;
        logic [7:0]  tb;
        logic [15:0] nd;
        logic [15:0] dt;
        logic        obusy;
        int          e_level;
        logic        e_ov;
        logic [15:0] e_data;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Reference model state
    ord_t mq[$];
    int   m_rd;
    bit   m_err;
    bit   p_push, p_pop;
    int   p_inc, p_dec;
    ord_t p_rec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iv, input logic [1:0] ty, input logic [7:0] tb,
                          input logic [15:0] nd, input logic [15:0] dt);
        in_valid = iv; in_type = ty; in_table = tb; in_node = nd; in_data = dt;
    endtask

    // Compare DUT against model mid-cycle and decide what the next edge does.
    task automatic at_neg();
        bit exp_ov;
        @(negedge clk);
        exp_ov = 1'b0;
        if (mq.size() > 0) exp_ov = !(mq[0].t == 2'd3 && m_rd == 4);
        chk("level", 64'(level), 64'(mq.size()));
        chk("in_busy", 64'(in_busy), 64'(mq.size() == 8));
        chk("order_valid", 64'(order_valid), 64'(exp_ov));
        chk("rd_outstanding", 64'(rd_outstanding), 64'(m_rd));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        if (mq.size() > 0) begin
            chk("head", 64'({order_type, order_table, order_node, order_data}), 64'(mq[0]));
        end
        p_push = in_valid && (mq.size() < 8);
        p_pop  = exp_ov && !order_busy;
        p_inc  = (p_pop && mq[0].t == 2'd3) ? 1 : 0;
        p_dec  = (dout_valid && !dout_busy) ? 1 : 0;
        p_rec  = '{t: in_type, tb: in_table, nd: in_node, dt: in_data};
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
        if (p_pop) void'(mq.pop_front());
        if (p_push) mq.push_back(p_rec);
        if (p_dec == 1 && p_inc == 0 && m_rd == 0) m_err = 1'b1;
        else m_rd = m_rd + p_inc - p_dec;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            at_neg();
            at_pos();
        end
    endtask

    // Asserts reset at the current time and checks its immediate effect.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_in_busy", 64'(in_busy), 64'(0));
        chk("rst_order_valid", 64'(order_valid), 64'(0));
        chk("rst_rd", 64'(rd_outstanding), 64'(0));
        chk("rst_err", 64'(rsp_err), 64'(0));
        mq.delete();
        m_rd = 0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        rst = 1'b0;
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        order_busy = 1'b0;
        dout_valid = 1'b0;
        dout_busy = 1'b0;
        m_rd = 0;
        m_err = 1'b0;
        #2;
        do_reset();

        // Three APPENDs flowing straight through
        vecs[0] = '{1'b1, 2'd0, 8'd3, 16'd1, 16'd111, 1'b0, 0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 2'd0, 8'd3, 16'd2, 16'd112, 1'b0, 1, 1'b1, 16'd111};
        vecs[2] = '{1'b1, 2'd0, 8'd3, 16'd1, 16'd113, 1'b0, 1, 1'b1, 16'd112};
        vecs[3] = '{1'b0, 2'd0, 8'd0, 16'd0, 16'd0,   1'b0, 1, 1'b1, 16'd113};
        vecs[4] = '{1'b0, 2'd0, 8'd0, 16'd0, 16'd0,   1'b0, 0, 1'b0, 16'd0};
        for (int i = 0; i < 5; i++) begin
            set_in(vecs[i].iv, vecs[i].ty, vecs[i].tb, vecs[i].nd, vecs[i].dt);
            order_busy = vecs[i].obusy;
            at_neg();
            chk("vec_level", 64'(level), 64'(vecs[i].e_level));
            chk("vec_order_valid", 64'(order_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov) chk("vec_order_data", 64'(order_data), 64'(vecs[i].e_data));
            at_pos();
        end

        // Fill to full with a stalled consumer; the 9th push is held off
        order_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, 2'd2, 8'(i), 16'(i), 16'(300 + i));
            tick(1);
        end
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        at_neg();
        chk("full_level", 64'(level), 64'(8));
        chk("full_in_busy", 64'(in_busy), 64'(1));
        at_pos();
        set_in(1'b1, 2'd1, 8'd9, 16'd9, 16'd99);
        order_busy = 1'b0;
        at_neg();
        chk("full_pop_busy", 64'(in_busy), 64'(1));
        at_pos();
        set_in(1'b1, 2'd1, 8'd10, 16'd10, 16'd100);
        order_busy = 1'b1;
        at_neg();
        chk("freed_level", 64'(level), 64'(7));
        chk("freed_in_busy", 64'(in_busy), 64'(0));
        at_pos();
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        order_busy = 1'b0;
        tick(10);

        // READ throttling at MAX_RD
        order_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 2'd3, 8'd1, 16'(i), 16'(200 + i));
            tick(1);
        end
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        order_busy = 1'b0;
        tick(6);
        at_neg();
        chk("rdmax_rd", 64'(rd_outstanding), 64'(4));
        chk("rdmax_ov", 64'(order_valid), 64'(0));
        chk("rdmax_head", 64'({order_type, order_data}), 64'({2'd3, 16'd204}));
        at_pos();
        dout_valid = 1'b1;
        tick(1);
        dout_valid = 1'b0;
        at_neg();
        chk("rd5_ov", 64'(order_valid), 64'(1));
        at_pos();
        at_neg();
        chk("rd5_rd", 64'(rd_outstanding), 64'(4));
        chk("rd5_level", 64'(level), 64'(0));
        at_pos();

        // Simultaneous READ issue and result consume at rd_outstanding=2
        dout_valid = 1'b1;
        tick(2);
        dout_valid = 1'b0;
        set_in(1'b1, 2'd3, 8'd2, 16'd7, 16'd77);
        tick(1);
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        dout_valid = 1'b1;
        at_neg();
        chk("both_rd_before", 64'(rd_outstanding), 64'(2));
        chk("both_ov", 64'(order_valid), 64'(1));
        at_pos();
        dout_valid = 1'b0;
        at_neg();
        chk("both_rd_after", 64'(rd_outstanding), 64'(2));
        at_pos();

        // Result consumed with nothing outstanding
        dout_valid = 1'b1;
        tick(3);
        dout_valid = 1'b0;
        tick(3);
        at_neg();
        chk("err_sticky", 64'(rsp_err), 64'(1));
        chk("err_rd_zero", 64'(rd_outstanding), 64'(0));
        at_pos();

        // Reset mid-cycle with orders queued behind a stall
        order_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 2'd0, 8'd4, 16'(i), 16'(400 + i));
            tick(1);
        end
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        chk("pre_rst_level", 64'(level), 64'(5));
        #2;
        do_reset();
        order_busy = 1'b0;
        set_in(1'b1, 2'd0, 8'd5, 16'd5, 16'd500);
        tick(1);
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        at_neg();
        chk("post_rst_push", 64'(order_data), 64'(500));
        at_pos();
        tick(2);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            set_in(($urandom % 3) != 0, 2'($urandom), 8'($urandom), 16'($urandom), 16'($urandom));
            order_busy = ($urandom % 4) == 0;
            dout_valid = ($urandom % 2) == 0;
            dout_busy  = ($urandom % 3) == 0;
            tick(1);
        end
        set_in(1'b0, 2'd0, 8'd0, 16'd0, 16'd0);
        dout_valid = 1'b0;
        order_busy = 1'b0;
        tick(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
